htif_responder: RTL and testbench
=================================

// Module: htif_responder
// PURPOSE
//   Host-side end of the tohost/fromhost mailbox in the control processor.
//   Detects a non-zero tohost value written by the target and captures it.
//   Clears tohost and presents the captured value to the host over a
//   valid/ready request channel.
//   Takes the host's reply on a valid/ready response channel and delivers it
//   into fromhost once the target has consumed the previous reply.
// PARAMETERS
//   RESP_TIMEOUT  0            cycles to wait for a host response in WAIT_RESP; 0 = wait forever
//   TIMEOUT_CODE  32'hFFFFFFFF value written to fromhost when RESP_TIMEOUT expires
// PORTS
//   clk              input   1   core clock
//   reset            input   1   reset; one clock; reset is asynchronous and active-low
//   tohost           input   32  current tohost PCR value
//   fromhost         input   32  current fromhost PCR value; 0 = empty
//   tohost_clear     output  1   one-cycle pulse: control processor zeroes tohost
//   fromhost_wr      output  1   one-cycle pulse: control processor loads fromhost_data
//   fromhost_data    output  32  value to load into fromhost
//   host_req_valid   output  1   request to host is valid
//   host_req_data    output  32  captured tohost value
//   host_req_ready   input   1   host accepts request
//   host_resp_valid  input   1   host response is valid
//   host_resp_data   input   32  host response value
//   host_resp_ready  output  1   block accepts response
//   busy             output  1   state != IDLE
//   req_count        output  16  number of requests accepted by host; wraps at 16'hFFFF -> 0
// BEHAVIOUR
// - All outputs are registered. Reset values: all outputs 0, state = IDLE, internal registers 0.
// - Reset assertion mid-transaction aborts the transaction immediately:
//   - the captured value is lost;
//   - no tohost_clear or fromhost_wr pulse is issued.
// - FSM: IDLE -> REQ -> WAIT_RESP -> FH_WAIT -> FH_WRITE -> IDLE.
// - IDLE:
//   - On an edge with tohost != 0: capture tohost into host_req_data, go to REQ.
//   - tohost_clear is high for exactly the first cycle in REQ.
//   - tohost == 0 is never a request.
// - REQ:
//   - host_req_valid = 1; host_req_data is stable until the handshake.
//   - Handshake = valid & ready on a rising edge. Then: host_req_valid drops next cycle,
//     req_count increments, go to WAIT_RESP.
//   - Minimum REQ duration is 1 cycle, so a stale tohost is never re-detected.
// - WAIT_RESP:
//   - host_resp_ready = 1. On resp valid & ready: latch host_resp_data into fromhost_data,
//     go to FH_WAIT.
//   - If RESP_TIMEOUT != 0: a counter starts at 0 on entry and increments each cycle.
//     When it reaches RESP_TIMEOUT - 1 with no handshake: fromhost_data = TIMEOUT_CODE,
//     go to FH_WAIT.
//   - A handshake on the expiry cycle takes priority over the timeout.
//   - host_resp_valid outside WAIT_RESP is ignored (host_resp_ready = 0).
// - FH_WAIT: waits until fromhost == 0 (target consumed the previous reply), then goes to FH_WRITE.
// - FH_WRITE: fromhost_wr = 1 for exactly one cycle, then IDLE.
// - Minimum end-to-end latency with ready/valid tied high and fromhost == 0:
//   - tohost detection to fromhost_wr = 4 cycles;
//   - the next request can be detected on the cycle after FH_WRITE.
// - A new tohost written by the target while busy is not sampled. It stays in tohost and is
//   serviced on return to IDLE.
// - Control processor contract for tohost_clear in the same cycle as a target tohost write:
//   the target write wins.
// - The block never re-checks or retries a clear.
// TESTING
// - Single transaction: tohost = 32'h00000123, req/resp ready/valid tied high,
//   resp = 32'h1, fromhost = 0 ->
//   host_req_data = 32'h123; one tohost_clear pulse; fromhost_wr with fromhost_data = 1
//   exactly 4 cycles after detection; req_count = 1.
// - Backpressure: host_req_ready low for 5 cycles, then high ->
//   host_req_valid held 6 cycles; data stable throughout; no second tohost_clear.
// - Fromhost full: fromhost = 32'h7 held 10 cycles after response ->
//   no fromhost_wr until the cycle after fromhost returns to 0.
// - Timeout: RESP_TIMEOUT = 8, host_resp_valid never asserted ->
//   fromhost_wr with fromhost_data = 32'hFFFFFFFF; state back in IDLE.
//   Response on expiry cycle -> response value is written, not TIMEOUT_CODE.
// - Reset mid-transaction: reset asserted while in WAIT_RESP ->
//   all outputs 0 asynchronously; no fromhost_wr after release; req_count = 0.
// - Back-to-back and wrap: target rewrites tohost = 32'h55 while busy ->
//   serviced immediately after FH_WRITE. Preload req_count = 16'hFFFF via 65535 requests,
//   one more -> req_count = 0.

Source files
------------

// File: rtl/htif_responder.sv
// Host-side tohost/fromhost mailbox responder: captures a target request, forwards it to
// the host over valid/ready, and writes the host reply (or a timeout code) into fromhost.
module htif_responder #(
    parameter int unsigned RESP_TIMEOUT = 0,
    parameter logic [31:0] TIMEOUT_CODE = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] tohost,
    input  logic [31:0] fromhost,
    output logic        tohost_clear,
    output logic        fromhost_wr,
    output logic [31:0] fromhost_data,
    output logic        host_req_valid,
    output logic [31:0] host_req_data,
    input  logic        host_req_ready,
    input  logic        host_resp_valid,
    input  logic [31:0] host_resp_data,
    output logic        host_resp_ready,
    output logic        busy,
    output logic [15:0] req_count
);

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned TW = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_FH_WAIT,
        S_FH_WRITE
    } state_t;

    state_t          r_state;
    logic            r_tohost_clear;
    logic            r_fromhost_wr;
    logic [DW-1:0]   r_fromhost_data;
    logic            r_req_valid;
    logic [DW-1:0]   r_req_data;
    logic            r_resp_ready;
    logic            r_busy;
    logic [CW-1:0]   r_req_count;
    logic [TW-1:0]   r_tmo;

    state_t          w_state;
    logic            w_tohost_clear;
    logic            w_fromhost_wr;
    logic [DW-1:0]   w_fromhost_data;
    logic            w_req_valid;
    logic [DW-1:0]   w_req_data;
    logic            w_resp_ready;
    logic            w_busy;
    logic [CW-1:0]   w_req_count;
    logic [TW-1:0]   w_tmo;
    logic            w_tmo_hit;

    // Next-state and next-output logic; every output is the registered copy of its w_ value.
    always_comb begin
        w_state         = r_state;
        w_tohost_clear  = 1'b0;
        w_fromhost_wr   = 1'b0;
        w_fromhost_data = r_fromhost_data;
        w_req_valid     = r_req_valid;
        w_req_data      = r_req_data;
        w_resp_ready    = r_resp_ready;
        w_req_count     = r_req_count;
        w_tmo           = r_tmo;
        w_tmo_hit       = (RESP_TIMEOUT != 0) && (r_tmo == TW'(RESP_TIMEOUT - 1));

        case (r_state)
            S_IDLE: begin
                if (tohost != '0) begin
                    w_req_data     = tohost;
                    w_req_valid    = 1'b1;
                    w_tohost_clear = 1'b1;
                    w_state        = S_REQ;
                end
            end
            S_REQ: begin
                if (r_req_valid && host_req_ready) begin
                    w_req_valid  = 1'b0;
                    w_req_count  = r_req_count + CW'(1);
                    w_tmo        = '0;
                    w_resp_ready = 1'b1;
                    w_state      = S_WAIT_RESP;
                end
            end
            S_WAIT_RESP: begin
                // A response on the expiry cycle beats the timeout.
                if (host_resp_valid && r_resp_ready) begin
                    w_fromhost_data = host_resp_data;
                    w_resp_ready    = 1'b0;
                    w_state         = S_FH_WAIT;
                end else if (w_tmo_hit) begin
                    w_fromhost_data = TIMEOUT_CODE;
                    w_resp_ready    = 1'b0;
                    w_state         = S_FH_WAIT;
                end else if (RESP_TIMEOUT != 0) begin
                    w_tmo = r_tmo + TW'(1);
                end
            end
            S_FH_WAIT: begin
                if (fromhost == '0) begin
                    w_fromhost_wr = 1'b1;
                    w_state       = S_FH_WRITE;
                end
            end
            S_FH_WRITE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_tohost_clear  <= 1'b0;
            r_fromhost_wr   <= 1'b0;
            r_fromhost_data <= '0;
            r_req_valid     <= 1'b0;
            r_req_data      <= '0;
            r_resp_ready    <= 1'b0;
            r_busy          <= 1'b0;
            r_req_count     <= '0;
            r_tmo           <= '0;
        end else begin
            r_state         <= w_state;
            r_tohost_clear  <= w_tohost_clear;
            r_fromhost_wr   <= w_fromhost_wr;
            r_fromhost_data <= w_fromhost_data;
            r_req_valid     <= w_req_valid;
            r_req_data      <= w_req_data;
            r_resp_ready    <= w_resp_ready;
            r_busy          <= w_busy;
            r_req_count     <= w_req_count;
            r_tmo           <= w_tmo;
        end
    end

    assign tohost_clear    = r_tohost_clear;
    assign fromhost_wr     = r_fromhost_wr;
    assign fromhost_data   = r_fromhost_data;
    assign host_req_valid  = r_req_valid;
    assign host_req_data   = r_req_data;
    assign host_resp_ready = r_resp_ready;
    assign busy            = r_busy;
    assign req_count       = r_req_count;

endmodule

// File: tb/tb_htif_responder.sv
// Bench for htif_responder: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model of the mailbox protocol.
module tb_htif_responder;

    localparam int unsigned TMO   = 8;
    localparam logic [31:0] TCODE = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] tohost = '0;
    logic [31:0] fromhost = '0;
    logic        tohost_clear;
    logic        fromhost_wr;
    logic [31:0] fromhost_data;
    logic        host_req_valid;
    logic [31:0] host_req_data;
    logic        host_req_ready = 1'b0;
    logic        host_resp_valid = 1'b0;
    logic [31:0] host_resp_data = '0;
    logic        host_resp_ready;
    logic        busy;
    logic [15:0] req_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fh_left = 0;
    int fh_hold = 0;
    int fh_zero_cyc = 0;
    bit chk_en = 1'b0;

    // Model expectations for the outputs during the cycle after each edge.
    logic        m_clear = 1'b0;
    logic        m_wr = 1'b0;
    logic [31:0] m_fdata = '0;
    logic        m_req_valid = 1'b0;
    logic [31:0] m_req_data = '0;
    logic        m_resp_ready = 1'b0;
    logic        m_busy = 1'b0;
    logic [15:0] m_count = '0;

    htif_responder #(
        .RESP_TIMEOUT (TMO),
        .TIMEOUT_CODE (TCODE)
    ) u_dut (
        .clk             (clk),
        .reset           (reset),
        .tohost          (tohost),
        .fromhost        (fromhost),
        .tohost_clear    (tohost_clear),
        .fromhost_wr     (fromhost_wr),
        .fromhost_data   (fromhost_data),
        .host_req_valid  (host_req_valid),
        .host_req_data   (host_req_data),
        .host_req_ready  (host_req_ready),
        .host_resp_valid (host_resp_valid),
        .host_resp_data  (host_resp_data),
        .host_resp_ready (host_resp_ready),
        .busy            (busy),
        .req_count       (req_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one procedural walk through a mailbox transaction; reset aborts it.
    task automatic mstep(output bit ab);
        @(posedge clk or negedge reset);
        ab = !reset;
    endtask

    task automatic m_zero();
        m_clear = 1'b0; m_wr = 1'b0; m_fdata = '0; m_req_valid = 1'b0;
        m_req_data = '0; m_resp_ready = 1'b0; m_busy = 1'b0; m_count = '0;
    endtask

    task automatic model_txn();
        bit ab;
        int unsigned n;
        do begin mstep(ab); if (ab) return; end while (tohost == 32'd0);
        m_req_data = tohost; m_req_valid = 1'b1; m_clear = 1'b1; m_busy = 1'b1;
        forever begin
            mstep(ab); if (ab) return;
            m_clear = 1'b0;
            if (host_req_ready) break;
        end
        m_req_valid = 1'b0; m_count = m_count + 16'd1; m_resp_ready = 1'b1;
        n = 0;
        forever begin
            mstep(ab); if (ab) return;
            if (host_resp_valid) begin m_fdata = host_resp_data; break; end
            n++;
            if (n == TMO) begin m_fdata = TCODE; break; end
        end
        m_resp_ready = 1'b0;
        do begin mstep(ab); if (ab) return; end while (fromhost != 32'd0);
        m_wr = 1'b1;
        mstep(ab); if (ab) return;
        m_wr = 1'b0; m_busy = 1'b0;
    endtask

    always begin
        if (!reset) begin
            m_zero();
            @(posedge reset);
        end else begin
            model_txn();
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("cmp_tohost_clear", 32'(tohost_clear), 32'(m_clear));
            chk("cmp_fromhost_wr", 32'(fromhost_wr), 32'(m_wr));
            chk("cmp_fromhost_data", fromhost_data, m_fdata);
            chk("cmp_req_valid", 32'(host_req_valid), 32'(m_req_valid));
            chk("cmp_req_data", host_req_data, m_req_data);
            chk("cmp_resp_ready", 32'(host_resp_ready), 32'(m_resp_ready));
            chk("cmp_busy", 32'(busy), 32'(m_busy));
            chk("cmp_req_count", 32'(req_count), 32'(m_count));
        end
    end

    // Control processor and target: clears tohost on request, target write wins,
    // loads fromhost on write, target consumes fromhost after fh_hold cycles.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (tohost_clear) tohost = '0;
        if (fromhost != '0) begin
            if (fh_left == 0) begin
                fromhost = '0;
                fh_zero_cyc = cyc;
            end else begin
                fh_left--;
            end
        end
        if (fromhost_wr) begin
            fromhost = fromhost_data;
            fh_left = fh_hold;
        end
    endtask

    task automatic drain();
        host_req_ready = 1'b1;
        host_resp_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (!busy && tohost == '0 && fromhost == '0) break;
            tick();
        end
        chk("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int wr_at;
        int nclr;
        int nvalid;
        int nwr;
        bit stable;
        logic [31:0] wr_data;

        #1 reset = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_flags", 32'({tohost_clear, fromhost_wr, host_req_valid, host_resp_ready, busy}), 32'd0);
        chk("rst_data", fromhost_data | host_req_data, 32'd0);
        chk("rst_count", 32'(req_count), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Single transaction, everything tied ready.
        drain();
        fh_hold = 0; host_resp_data = 32'h1;
        tohost = 32'h0000_0123;
        tick();
        chk("single_clear", 32'(tohost_clear), 32'd1);
        chk("single_req_data", host_req_data, 32'h123);
        nclr = 0; wr_at = 0; wr_data = '0;
        for (int i = 2; i <= 20; i++) begin
            tick();
            if (tohost_clear) nclr++;
            if (fromhost_wr) begin wr_at = i; wr_data = fromhost_data; break; end
        end
        chk("single_wr_latency", 32'(wr_at), 32'd4);
        chk("single_wr_data", wr_data, 32'h1);
        chk("single_count", 32'(req_count), 32'd1);
        chk("single_extra_clear", 32'(nclr), 32'd0);
        tick();
        chk("single_idle", 32'(busy), 32'd0);

        // Request backpressure.
        drain();
        host_req_ready = 1'b0;
        tohost = 32'h0000_0ABC;
        nvalid = 0; nclr = 0; stable = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (host_req_valid) begin
                nvalid++;
                if (host_req_data != 32'h0000_0ABC) stable = 1'b0;
            end
            if (tohost_clear) nclr++;
            if (i == 6) host_req_ready = 1'b1;
        end
        chk("bp_valid_cycles", 32'(nvalid), 32'd6);
        chk("bp_data_stable", 32'(stable), 32'd1);
        chk("bp_clear_pulses", 32'(nclr), 32'd1);

        // fromhost still full when the reply arrives.
        drain();
        host_resp_data = 32'h2222;
        fromhost = 32'h7; fh_left = 9; fh_zero_cyc = 0;
        tohost = 32'h31;
        wr_at = 0; wr_data = '0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (fromhost_wr) begin wr_at = cyc; wr_data = fromhost_data; break; end
        end
        chk("ff_wr_after_empty", 32'(wr_at - fh_zero_cyc), 32'd1);
        chk("ff_wr_data", wr_data, 32'h2222);

        // Response timeout.
        drain();
        host_resp_valid = 1'b0;
        tohost = 32'h77;
        wr_at = 0; wr_data = '0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (fromhost_wr) begin wr_at = i; wr_data = fromhost_data; break; end
        end
        chk("tmo_wr_at", 32'(wr_at), 32'd11);
        chk("tmo_wr_data", wr_data, 32'hFFFF_FFFF);
        tick();
        chk("tmo_idle", 32'(busy), 32'd0);

        // Response arriving on the expiry cycle.
        drain();
        host_resp_valid = 1'b0;
        host_resp_data = 32'hBEEF;
        tohost = 32'h78;
        wr_at = 0; wr_data = '0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (fromhost_wr) begin wr_at = i; wr_data = fromhost_data; break; end
            if (i == 9) host_resp_valid = 1'b1;
            if (i == 10) host_resp_valid = 1'b0;
        end
        chk("exp_wr_at", 32'(wr_at), 32'd11);
        chk("exp_wr_data", wr_data, 32'hBEEF);

        // Target rewrites tohost while busy.
        drain();
        host_resp_data = 32'h5;
        tohost = 32'h44;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 2) tohost = 32'h55;
            if (i == 5) chk("b2b_gap_valid", 32'(host_req_valid), 32'd0);
            if (i == 6) begin
                chk("b2b_next_valid", 32'(host_req_valid), 32'd1);
                chk("b2b_next_data", host_req_data, 32'h55);
            end
        end

        // Reset in WAIT_RESP.
        drain();
        host_resp_valid = 1'b0;
        tohost = 32'h99;
        tick();
        tick();
        chk("rm_in_wait", 32'(host_resp_ready), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("rm_async_flags", 32'({tohost_clear, fromhost_wr, host_req_valid, host_resp_ready, busy}), 32'd0);
        chk("rm_async_data", fromhost_data | host_req_data, 32'd0);
        tick();
        tick();
        reset = 1'b1;
        host_resp_valid = 1'b1;
        nwr = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fromhost_wr) nwr++;
        end
        chk("rm_no_wr", 32'(nwr), 32'd0);
        chk("rm_count", 32'(req_count), 32'd0);

        // Counter wrap from a preloaded all-ones count.
        drain();
        force u_dut.r_req_count = 16'hFFFF;
        m_count = 16'hFFFF;
        tick();
        tick();
        release u_dut.r_req_count;
        tohost = 32'h66;
        tick();
        chk("wrap_before", 32'(req_count), 32'h0000_FFFF);
        tick();
        chk("wrap_zero", 32'(req_count), 32'd0);

        // Random traffic.
        drain();
        for (int i = 0; i < 3000; i++) begin
            tick();
            host_req_ready = ($urandom_range(0, 2) != 0);
            host_resp_valid = ($urandom_range(0, 3) == 0);
            host_resp_data = $urandom;
            fh_hold = int'($urandom_range(0, 6));
            if ($urandom_range(0, 5) == 0)
                tohost = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b0;
                tick();
                tick();
                reset = 1'b1;
            end
        end
        tohost = '0;
        drain();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
